// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC owner, in-order imem fetch, instruction buffer
//
// Purpose:
//   Owns the fetch PC and issues word fetches to instruction memory. A credit
//   count (in-flight + buffered <= BUF_DEPTH) keeps the buffer from ever
//   overflowing. Instructions are handed to decode over a valid/ready
//   handshake. A redirect from execute restarts fetch at a new PC and drops
//   every response that belongs to the wrong path.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   When defined, a redirect target with bits[1:0] != 0 delivers one entry
//   flagged id_misalign = 1 with a nop word and the raw target PC. Fetch then
//   stays halted until the next redirect. When undefined, target bits[1:0]
//   are cleared before use.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel (word address)
//   imem_rsp_valid/data              in-order fetch responses
//   redirect_valid/pc                one-cycle control-flow change from execute
//   id_valid/ready                   decode handshake
//   id_instr, id_pc, id_pc_plus4     head instruction, its PC, and PC + 4
//   id_misalign                      (macro only) head entry came from a misaligned redirect

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        id_misalign
`endif
);

   localparam int          PW      = $clog2(BUF_DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc, rsp_pc;
   logic [CW-1:0] inflight, inflight_d;
   logic [CW-1:0] drop_cnt, drop_d;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   buf_instr [BUF_DEPTH];
   logic [31:0]   buf_pc    [BUF_DEPTH];
   logic [CW:0]   used;
   logic          accept, rsp_ok, keep, push, pop;
   logic [31:0]   redir_target;
   logic [31:0]   push_instr, push_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic          buf_mis [BUF_DEPTH];
   logic          halted, mis_pend, mis_push, redir_mis, push_mis;
   logic [31:0]   mis_pc;
`endif

   // Credits: every accepted request owns a buffer slot until it is popped
   // or dropped, so the buffer cannot overflow.
   assign used = {1'b0, inflight} + {1'b0, count};

`ifdef FETCH_MISALIGN_CHECK_EN
   assign imem_req_valid = (state_q != IDLE) && (used < DEPTH_C) && !halted;
`else
   assign imem_req_valid = (state_q != IDLE) && (used < DEPTH_C);
`endif
   assign imem_req_addr  = fetch_pc;

   assign id_valid    = (count != '0);
   assign id_instr    = id_valid ? buf_instr[rd_ptr] : 32'd0;
   assign id_pc       = id_valid ? buf_pc[rd_ptr]    : 32'd0;
   assign id_pc_plus4 = id_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign id_misalign = id_valid && buf_mis[rd_ptr];
`endif

   always_comb begin
      state_d    = state_q;
      accept     = imem_req_valid && imem_req_ready;
      // A response with nothing outstanding is a protocol error; ignore it.
      rsp_ok     = imem_rsp_valid && (inflight != '0);
      // A response arriving with a redirect is wrong-path by definition.
      keep       = rsp_ok && (drop_cnt == '0) && !redirect_valid;
      pop        = id_valid && id_ready;
      push       = keep;
      push_instr = imem_rsp_data;
      push_pc    = rsp_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
      redir_target = redirect_pc;
      redir_mis    = (redirect_pc[1:0] != 2'b00);
      // Fetch is halted, so once nothing is outstanding the flagged nop can
      // take a slot in the (just flushed) buffer.
      mis_push     = mis_pend && (inflight == '0) && !redirect_valid;
      push_mis     = mis_push;
      if (mis_push) begin
         push       = 1'b1;
         push_instr = NOP;
         push_pc    = mis_pc;
      end
`else
      redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif
      inflight_d = inflight + CW'(accept) - CW'(rsp_ok);
      // On redirect every outstanding request, including one accepted this
      // cycle, is wrong-path; this equals the next in-flight count.
      if (redirect_valid)
         drop_d = inflight_d;
      else if (rsp_ok && (drop_cnt != '0))
         drop_d = drop_cnt - CW'(1);
      else
         drop_d = drop_cnt;

      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     state_d = RUN;
         FLUSH:   if (drop_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (redirect_valid)
         state_d = (drop_d != '0) ? FLUSH : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         halted   <= 1'b0;
         mis_pend <= 1'b0;
         mis_pc   <= 32'd0;
`endif
      end else begin
         state_q  <= state_d;
         inflight <= inflight_d;
         drop_cnt <= drop_d;
         if (redirect_valid) begin
            // Any pop this cycle is subsumed by the flush.
            fetch_pc <= redir_target;
            rsp_pc   <= redir_target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halted   <= redir_mis;
            mis_pend <= redir_mis;
            mis_pc   <= redirect_pc;
`endif
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (keep)   rsp_pc   <= rsp_pc + 32'd4;
            if (push)   wr_ptr   <= wr_ptr + PW'(1);
            if (pop)    rd_ptr   <= rd_ptr + PW'(1);
            if (push && !pop)
               count <= count + CW'(1);
            else if (pop && !push)
               count <= count - CW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (mis_push) mis_pend <= 1'b0;
`endif
         end
      end
   end

   // Buffer storage needs no reset: id_* are gated by id_valid.
   always_ff @(posedge clk) begin
      if (!rst && !redirect_valid && push) begin
         buf_instr[wr_ptr] <= push_instr;
         buf_pc[wr_ptr]    <= push_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
         buf_mis[wr_ptr]   <= push_mis;
`endif
      end
   end

endmodule
